// File: rtl/maze_ram_arbiter.sv
// maze_ram_arbiter
// Shares the single-port maze tile RAM between the pixel renderer and the
// game-logic writer, paces game logic with a per-frame tick, and limits the
// number of writes accepted per frame.
//
// Ports
//   clk, clr          pixel clock, asynchronous active-high reset
//   vidon, vsync      VGA timing: active-video flag, vertical sync pulse
//   PixelX, PixelY    active-area pixel coordinate
//   wr_req/addr/data  writer request (held stable until wr_ack)
//   wr_ack, wr_err    request consumed / consumed but dropped (out of range)
//   ram_*             single-port RAM bus (synchronous read, 1-cycle latency)
//   tile_data/valid   tile code for the pixel sampled two clocks earlier
//   frame_tick        one-cycle pulse on vsync rising edge
//   frame_count       frames since reset (wraps)
//   budget_full       MAX_WR writes accepted in the current frame
//   dbg_state_o       arbiter FSM state (BLANK=0, WRITE=1)
//
// Handshake: the writer raises wr_req with wr_addr/wr_data and holds all three
// stable until it sees wr_ack for one cycle; the request is consumed in that
// cycle whether it was written (ram_we=1) or dropped (wr_err=1). A request is
// only granted while vidon is low, the budget is not full, and the previous
// write has finished, so throughput is at most one write every two cycles.

module maze_ram_arbiter #(
  parameter int TILE_SHIFT = 4,
  parameter int COLS       = 50,
  parameter int ROWS       = 38,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 4,
  parameter int MAX_WR     = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              vidon,
  input  logic              vsync,
  input  logic [10:0]       PixelX,
  input  logic [10:0]       PixelY,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tile_data,
  output logic              tile_valid,
  output logic              frame_tick,
  output logic [15:0]       frame_count,
  output logic              budget_full,
  output logic [0:0]        dbg_state_o
);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  localparam int                CNT_W   = $clog2(MAX_WR + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WR);
  localparam logic [ADDR_W-1:0] N_TILES = ADDR_W'(COLS * ROWS);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_slot_q, rd_slot_d;   // a read address is on the bus
  logic              rd_pend_q, rd_pend_d;   // RAM is returning that read
  logic [DATA_W-1:0] tile_data_q, tile_data_d;
  logic              tile_valid_q, tile_valid_d;
  logic              vsync_q;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic [ADDR_W-1:0] tile_row, tile_col, rd_addr;
  logic              grant, wr_in_range;

  // Tile index of the current pixel; arithmetic modulo 2^ADDR_W.
  assign tile_row = ADDR_W'(PixelY >> TILE_SHIFT);
  assign tile_col = ADDR_W'(PixelX >> TILE_SHIFT);
  assign rd_addr  = ADDR_W'(tile_row * ADDR_W'(COLS)) + tile_col;

  assign frame_tick  = vsync & ~vsync_q;
  assign budget_full = (wr_cnt_q == CNT_MAX);
  assign wr_in_range = (wr_addr < N_TILES);
  assign grant       = (state_q == BLANK) && wr_req && !vidon && !budget_full;

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;   // idle bus holds the last address
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    rd_slot_d   = 1'b0;

    if (state_q == WRITE) begin
      // The write occupies this slot: a vidon sample taken now issues no
      // read, which shows up as a tile_valid gap two clocks later.
      state_d = BLANK;
    end else if (grant) begin
      state_d     = WRITE;
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
      ram_we_d    = wr_in_range;
      wr_err_d    = !wr_in_range;
    end else if (vidon) begin
      ram_addr_d = rd_addr;
      rd_slot_d  = 1'b1;
    end
  end

  always_comb begin
    rd_pend_d    = rd_slot_q;
    tile_valid_d = rd_pend_q;
    tile_data_d  = rd_pend_q ? ram_rdata : tile_data_q;

    frame_count_d = frame_tick ? frame_count_q + 16'd1 : frame_count_q;

    // A new frame clears the budget but still counts an ack in the same cycle.
    if (frame_tick) begin
      wr_cnt_d = wr_ack_q ? CNT_W'(1) : '0;
    end else if (wr_ack_q) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= BLANK;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_slot_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      tile_data_q   <= '0;
      tile_valid_q  <= 1'b0;
      vsync_q       <= 1'b0;
      frame_count_q <= '0;
      wr_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      wr_ack_q      <= wr_ack_d;
      wr_err_q      <= wr_err_d;
      rd_slot_q     <= rd_slot_d;
      rd_pend_q     <= rd_pend_d;
      tile_data_q   <= tile_data_d;
      tile_valid_q  <= tile_valid_d;
      vsync_q       <= vsync;
      frame_count_q <= frame_count_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign tile_data   = tile_data_q;
  assign tile_valid  = tile_valid_q;
  assign frame_count = frame_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Directed testbench for maze_ram_arbiter with a behavioural tile RAM.
module tb_maze_ram_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        vidon = 1'b0;
  logic        vsync = 1'b0;
  logic [10:0] PixelX = '0;
  logic [10:0] PixelY = '0;
  logic        wr_req = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        wr_ack, wr_err, ram_we, tile_valid, frame_tick, budget_full;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata, ram_rdata, tile_data;
  logic [15:0] frame_count;
  logic [0:0]  dbg_state;

  logic [3:0]  mem [0:2047];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          fc_exp = 0;

  always #5 clk = ~clk;

  maze_ram_arbiter dut (
    .clk(clk), .clr(clr), .vidon(vidon), .vsync(vsync),
    .PixelX(PixelX), .PixelY(PixelY),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .tile_data(tile_data), .tile_valid(tile_valid),
    .frame_tick(frame_tick), .frame_count(frame_count),
    .budget_full(budget_full), .dbg_state_o(dbg_state)
  );

  // Tile RAM: every tile holds 0xA except tile 52 which holds 0x7.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i == 52) ? 4'h7 : 4'hA;
      ram_rdata <= 4'h0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    fc_exp++;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ram_addr !== 11'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
    n_cmp++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tile_valid: got %b want 0", tile_valid); end
    n_cmp++; if (tile_data !== 4'h0) begin n_fail++; $display("FAIL reset_tile_data: got %h want 0", tile_data); end
    n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (budget_full !== 1'b0) begin n_fail++; $display("FAIL reset_budget_full: got %b want 0", budget_full); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_read;
    // Tile (row 1, col 2) -> 1*50+2 = 52, holding 0x7.
    vidon = 1'b1; PixelX = 11'd35; PixelY = 11'd20;
    tick();
    n_cmp++; if (ram_addr !== 11'd52) begin n_fail++; $display("FAIL read_addr: got %0d want 52", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b want 0", ram_we); end
    tick();
    tick();
    n_cmp++; if (tile_data !== 4'h7) begin n_fail++; $display("FAIL read_tile_data: got %h want 7", tile_data); end
    n_cmp++; if (tile_valid !== 1'b1) begin n_fail++; $display("FAIL read_tile_valid: got %b want 1", tile_valid); end
    vidon = 1'b0;
    repeat (3) tick();
    n_cmp++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL read_drain_valid: got %b want 0", tile_valid); end
  endtask

  task automatic test_write;
    wr_req = 1'b1; wr_addr = 11'd100; wr_data = 4'h3;
    tick();
    n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL write_ack: got %b want 1", wr_ack); end
    n_cmp++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", ram_we); end
    n_cmp++; if (ram_addr !== 11'd100) begin n_fail++; $display("FAIL write_addr: got %0d want 100", ram_addr); end
    n_cmp++; if (ram_wdata !== 4'h3) begin n_fail++; $display("FAIL write_wdata: got %h want 3", ram_wdata); end
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", wr_err); end
    wr_req = 1'b0;
    tick();
    n_cmp++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL write_ack_pulse: got %b want 0", wr_ack); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL write_we_pulse: got %b want 0", ram_we); end
    // Read back tile 100 = row 2, col 0.
    vidon = 1'b1; PixelX = 11'd0; PixelY = 11'd32;
    tick();
    n_cmp++; if (ram_addr !== 11'd100) begin n_fail++; $display("FAIL readback_addr: got %0d want 100", ram_addr); end
    tick();
    tick();
    n_cmp++; if (tile_data !== 4'h3) begin n_fail++; $display("FAIL readback_data: got %h want 3", tile_data); end
    vidon = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_vidon_block;
    int bad;
    bad = 0;
    vidon = 1'b1; PixelX = 11'd0; PixelY = 11'd0;
    wr_req = 1'b1; wr_addr = 11'd200; wr_data = 4'h5;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (wr_ack || ram_we) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL block_no_ack: got %0d acks/we want 0", bad); end
    n_cmp++; if (tile_valid !== 1'b1 || tile_data !== 4'hA) begin n_fail++; $display("FAIL block_reads: got valid=%b data=%h want 1/a", tile_valid, tile_data); end
    vidon = 1'b0;
    tick();
    n_cmp++; if (wr_ack !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL block_release: got ack=%b we=%b want 1/1", wr_ack, ram_we); end
    n_cmp++; if (ram_addr !== 11'd200) begin n_fail++; $display("FAIL block_addr: got %0d want 200", ram_addr); end
    wr_req = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range;
    wr_req = 1'b1; wr_addr = 11'd1900; wr_data = 4'hF;
    tick();
    n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL oob_ack: got %b want 1", wr_ack); end
    n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %b want 1", wr_err); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL oob_we: got %b want 0", ram_we); end
    wr_req = 1'b0;
    tick();
    n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL oob_err_pulse: got %b want 0", wr_err); end
    n_cmp++; if (mem[1900] !== 4'hA) begin n_fail++; $display("FAIL oob_ram: got %h want a", mem[1900]); end
  endtask

  task automatic test_back_to_back;
    int acks, dbl;
    logic prev;
    pulse_vsync();
    n_cmp++; if (frame_count !== 16'(fc_exp)) begin n_fail++; $display("FAIL b2b_frame_start: got %0d want %0d", frame_count, fc_exp); end
    acks = 0; dbl = 0; prev = 1'b0;
    wr_req = 1'b1; wr_addr = 11'd300; wr_data = 4'h0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (wr_ack) begin
        if (prev) dbl++;
        acks++;
        wr_addr = 11'(300 + acks);
        wr_data = 4'(acks);
      end
      prev = wr_ack;
    end
    n_cmp++; if (acks !== 64) begin n_fail++; $display("FAIL b2b_acks: got %0d want 64", acks); end
    n_cmp++; if (dbl !== 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d adjacent acks want 0", dbl); end
    n_cmp++; if (budget_full !== 1'b1) begin n_fail++; $display("FAIL b2b_budget_full: got %b want 1", budget_full); end
    n_cmp++; if (mem[305] !== 4'h5) begin n_fail++; $display("FAIL b2b_ram: got %h want 5", mem[305]); end
    pulse_vsync();
    for (int c = 0; c < 50; c++) begin
      tick();
      if (wr_ack) begin
        acks++;
        wr_addr = 11'(300 + acks);
        wr_data = 4'(acks);
        if (acks == 70) wr_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    n_cmp++; if (acks !== 70) begin n_fail++; $display("FAIL b2b_total: got %0d want 70", acks); end
    n_cmp++; if (budget_full !== 1'b0) begin n_fail++; $display("FAIL b2b_budget_clear: got %b want 0", budget_full); end
    n_cmp++; if (frame_count !== 16'(fc_exp)) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_tick_with_ack;
    int acks;
    wr_req = 1'b1; wr_addr = 11'd400; wr_data = 4'h1;
    tick();
    n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL tickack_ack: got %b want 1", wr_ack); end
    vsync = 1'b1;
    #1;
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tickack_tick: got %b want 1", frame_tick); end
    wr_addr = 11'd401;
    tick();
    vsync = 1'b0;
    fc_exp++;
    // The coinciding ack is the first of the new frame: 63 more fit.
    acks = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (wr_ack) begin
        acks++;
        wr_addr = 11'(401 + acks);
        wr_data = 4'(acks);
      end
    end
    wr_req = 1'b0;
    n_cmp++; if (acks !== 63) begin n_fail++; $display("FAIL tickack_count: got %0d want 63", acks); end
    n_cmp++; if (budget_full !== 1'b1) begin n_fail++; $display("FAIL tickack_full: got %b want 1", budget_full); end
    n_cmp++; if (frame_count !== 16'(fc_exp)) begin n_fail++; $display("FAIL tickack_frames: got %0d want %0d", frame_count, fc_exp); end
    pulse_vsync();
  endtask

  task automatic test_write_into_video;
    vidon = 1'b0;
    wr_req = 1'b1; wr_addr = 11'd60; wr_data = 4'h9;
    tick();
    n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL edge_ack: got %b want 1", wr_ack); end
    vidon = 1'b1; PixelX = 11'd35; PixelY = 11'd20;
    wr_req = 1'b0;
    tick();
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 11'd60) begin n_fail++; $display("FAIL edge_lost_slot: got we=%b addr=%0d want 0/60", ram_we, ram_addr); end
    n_cmp++; if (mem[60] !== 4'h9) begin n_fail++; $display("FAIL edge_write_landed: got %h want 9", mem[60]); end
    tick();
    n_cmp++; if (ram_addr !== 11'd52) begin n_fail++; $display("FAIL edge_read_addr: got %0d want 52", ram_addr); end
    tick();
    n_cmp++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL edge_gap: got %b want 0", tile_valid); end
    tick();
    n_cmp++; if (tile_valid !== 1'b1 || tile_data !== 4'h7) begin n_fail++; $display("FAIL edge_resume: got valid=%b data=%h want 1/7", tile_valid, tile_data); end
  endtask

  task automatic test_async_clear;
    #2;
    clr = 1'b1;
    #1;
    n_cmp++; if (tile_valid !== 1'b0 || tile_data !== 4'h0) begin n_fail++; $display("FAIL clr_tile: got valid=%b data=%h want 0/0", tile_valid, tile_data); end
    n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL clr_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (ram_addr !== 11'd0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL clr_ram: got addr=%0d we=%b want 0/0", ram_addr, ram_we); end
    n_cmp++; if (budget_full !== 1'b0 || wr_ack !== 1'b0) begin n_fail++; $display("FAIL clr_handshake: got full=%b ack=%b want 0/0", budget_full, wr_ack); end
    @(negedge clk);
    clr = 1'b0;
    vidon = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_vidon_block();
    test_out_of_range();
    test_back_to_back();
    test_tick_with_ack();
    test_write_into_video();
    test_async_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
